// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive front end with 16x oversampling, 5-8 data bits, optional parity, one stop bit.
// Ports:
//   CLK, reset            system clock, synchronous active-high reset
//   RxD                   asynchronous serial input, idles high
//   divisor               clocks per 16x tick, 0 disables the receiver
//   wls, pen, eps         word length (5+wls bits), parity enable, even parity select
//   rd_ack, err_clr       RBR read pulse, sticky error clear pulse
//   rx_data, data_ready   receive buffer register and its unread flag
//   rx_strobe             one-cycle pulse when the RBR is loaded
//   overrun_err, parity_err, frame_err, break_det   sticky line-status flags
//   rx_busy               a frame is in progress
module uart_rx_deser #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             RxD,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       wls,
  input  logic             pen,
  input  logic             eps,
  input  logic             rd_ack,
  input  logic             err_clr,
  output logic [7:0]       rx_data,
  output logic             data_ready,
  output logic             rx_strobe,
  output logic             overrun_err,
  output logic             parity_err,
  output logic             frame_err,
  output logic             break_det,
  output logic             rx_busy
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd;
  logic [2:0]             state;
  logic [DIV_W-1:0]       presc;
  logic [3:0]             cnt;
  logic [2:0]             idx;
  logic [7:0]             sh;
  logic [7:0]             word;
  logic                   par, zero, pe, armed;
  logic                   en, tick, mid, sample, last, done;
  assign rxd     = sync[SYNC_STAGES-1];
  assign en      = divisor != '0;
  // >= rather than == so a divisor lowered mid-frame cannot strand the prescaler
  assign tick    = en && state != IDLE && presc >= divisor - DIV_W'(1);
  assign mid     = tick && cnt == 4'd7;
  assign sample  = tick && cnt == 4'd15;
  assign last    = idx == {1'b0, wls} + 3'd4;
  assign done    = state == STOP && sample;
  // data enters at the MSB, so a short word sits in the upper bits until shifted down
  assign word    = sh >> (2'd3 - wls);
  assign rx_busy = state != IDLE;
  always_ff @(posedge CLK) begin
    if (reset) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], RxD};
  end
  always_ff @(posedge CLK) begin
    if (reset || !en || state == IDLE || tick) presc <= '0;
    else presc <= presc + DIV_W'(1);
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      zero  <= 1'b1;
      pe    <= 1'b0;
      armed <= 1'b1;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (tick) cnt <= cnt + 4'd1;
      case (state)
        IDLE: begin
          // after a framing error the line must go high before a new start is accepted
          armed <= armed | rxd;
          if (!rxd && armed) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: if (mid) begin
          cnt <= '0;
          if (rxd) state <= IDLE;
          else begin
            state <= DATA;
            idx   <= '0;
            par   <= 1'b0;
            zero  <= 1'b1;
            pe    <= 1'b0;
          end
        end
        DATA: if (sample) begin
          sh   <= {rxd, sh[7:1]};
          par  <= par ^ rxd;
          zero <= zero & ~rxd;
          idx  <= idx + 3'd1;
          if (last) state <= pen ? PARITY : STOP;
        end
        PARITY: if (sample) begin
          pe    <= par ^ rxd ^ ~eps;
          zero  <= zero & ~rxd;
          state <= STOP;
        end
        STOP: if (sample) begin
          state <= IDLE;
          armed <= rxd;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_data     <= '0;
      data_ready  <= 1'b0;
      rx_strobe   <= 1'b0;
      overrun_err <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      rx_strobe   <= done;
      if (done) rx_data <= word;
      data_ready  <= done | (data_ready & ~rd_ack);
      overrun_err <= (overrun_err & ~err_clr) | (done & data_ready & ~rd_ack);
      parity_err  <= (parity_err & ~err_clr) | (done & pe);
      frame_err   <= (frame_err & ~err_clr) | (done & ~rxd);
      break_det   <= (break_det & ~err_clr) | (done & ~rxd & zero);
    end
  end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: scoreboard bench for uart_rx_deser
module tb_uart_rx_deser;
  localparam int BIT = 432;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        RxD = 1'b1;
  logic [15:0] divisor = 16'd27;
  logic [1:0]  wls = 2'b11;
  logic        pen = 1'b0;
  logic        eps = 1'b0;
  logic        rd_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  rx_data;
  logic        data_ready, rx_strobe, overrun_err, parity_err, frame_err, break_det, rx_busy;
  int          total = 0;
  int          bad = 0;
  int          strobes = 0;
  logic [7:0]  exp_q[$];
  uart_rx_deser dut (
    .CLK(CLK), .reset(reset), .RxD(RxD), .divisor(divisor), .wls(wls), .pen(pen), .eps(eps),
    .rd_ack(rd_ack), .err_clr(err_clr), .rx_data(rx_data), .data_ready(data_ready),
    .rx_strobe(rx_strobe), .overrun_err(overrun_err), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .rx_busy(rx_busy)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (!reset && rx_strobe) begin
      strobes++;
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end
  task automatic bit_t(input logic b, input int n);
    RxD = b;
    repeat (n) @(negedge CLK);
  endtask
  task automatic send(input logic [7:0] d, input int n, input bit p_en, input logic p, input logic stop);
    bit_t(1'b0, BIT);
    for (int i = 0; i < n; i++) bit_t(d[i], BIT);
    if (p_en) bit_t(p, BIT);
    bit_t(stop, BIT);
  endtask
  task automatic expect_byte(input logic [7:0] d, input int n);
    logic [7:0] m;
    m = 8'hff >> (8 - n);
    exp_q.push_back(d & m);
  endtask
  task automatic pulse_clr();
    rd_ack = 1'b1;
    err_clr = 1'b1;
    @(negedge CLK);
    rd_ack = 1'b0;
    err_clr = 1'b0;
  endtask
  task automatic flags(input string tag, input logic dr, input logic ov, input logic pe, input logic fe, input logic bd);
    chk({tag, "_dr"}, {31'd0, data_ready}, {31'd0, dr});
    chk({tag, "_ov"}, {31'd0, overrun_err}, {31'd0, ov});
    chk({tag, "_pe"}, {31'd0, parity_err}, {31'd0, pe});
    chk({tag, "_fe"}, {31'd0, frame_err}, {31'd0, fe});
    chk({tag, "_bd"}, {31'd0, break_det}, {31'd0, bd});
  endtask
  function automatic logic xor_bits(input logic [7:0] d, input int n);
    logic x;
    x = 1'b0;
    for (int i = 0; i < n; i++) x ^= d[i];
    return x;
  endfunction
  initial begin
    int s0;
    int busy_seen;
    logic [7:0] d;
    logic [9:0] raw;
    repeat (4) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_strobe", {31'd0, rx_strobe}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 8N1 raw frame, LSB first
    s0 = strobes;
    raw = 10'b1100101100;
    exp_q.push_back(8'h96);
    for (int i = 0; i < 10; i++) bit_t(raw[i], BIT);
    bit_t(1'b1, BIT);
    chk("t1_strobes", strobes - s0, 32'd1);
    chk("t1_busy", {31'd0, rx_busy}, 32'd0);
    flags("t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // back-to-back without read -> overrun
    pulse_clr();
    s0 = strobes;
    expect_byte(8'h55, 8);
    send(8'h55, 8, 1'b0, 1'b0, 1'b1);
    expect_byte(8'hA3, 8);
    send(8'hA3, 8, 1'b0, 1'b0, 1'b1);
    bit_t(1'b1, BIT);
    chk("t2_strobes", strobes - s0, 32'd2);
    chk("t2_rx_data", {24'd0, rx_data}, 32'hA3);
    flags("t2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // same with a read in between
    pulse_clr();
    expect_byte(8'h55, 8);
    send(8'h55, 8, 1'b0, 1'b0, 1'b1);
    pulse_clr();
    bit_t(1'b1, BIT);
    expect_byte(8'hA3, 8);
    send(8'hA3, 8, 1'b0, 1'b0, 1'b1);
    bit_t(1'b1, BIT);
    flags("t2b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // 7E1
    pulse_clr();
    wls = 2'b10;
    pen = 1'b1;
    eps = 1'b1;
    d = 8'h41;
    expect_byte(d, 7);
    send(d, 7, 1'b1, xor_bits(d, 7), 1'b1);
    bit_t(1'b1, BIT);
    flags("t3_good", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    expect_byte(d, 7);
    send(d, 7, 1'b1, ~xor_bits(d, 7), 1'b1);
    bit_t(1'b1, BIT);
    flags("t3_bad", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    flags("t3_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // break: 20 bit times low, 8N1
    wls = 2'b11;
    pen = 1'b0;
    s0 = strobes;
    exp_q.push_back(8'h00);
    bit_t(1'b0, 20 * BIT);
    chk("brk_strobes", strobes - s0, 32'd1);
    bit_t(1'b1, 2 * BIT);
    chk("brk_rx_data", {24'd0, rx_data}, 32'd0);
    flags("brk", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("brk_strobes_after", strobes - s0, 32'd1);
    // glitch shorter than half a bit
    pulse_clr();
    s0 = strobes;
    bit_t(1'b0, 100);
    bit_t(1'b1, 600);
    chk("gl_busy", {31'd0, rx_busy}, 32'd0);
    chk("gl_strobes", strobes - s0, 32'd0);
    flags("gl", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset in the middle of DATA
    expect_byte(8'h5A, 8);
    send(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    bit_t(1'b0, BIT);
    bit_t(1'b1, BIT);
    bit_t(1'b0, BIT);
    chk("mid_busy", {31'd0, rx_busy}, 32'd1);
    reset = 1'b1;
    RxD = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk("rstmid_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rstmid_busy", {31'd0, rx_busy}, 32'd0);
    flags("rstmid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_t(1'b1, 2 * BIT);
    expect_byte(8'hC7, 8);
    send(8'hC7, 8, 1'b0, 1'b0, 1'b1);
    bit_t(1'b1, BIT);
    flags("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // receiver disabled
    pulse_clr();
    divisor = 16'd0;
    s0 = strobes;
    busy_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      RxD = (i % 150) < 75 ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (rx_busy) busy_seen++;
    end
    chk("dis_busy", busy_seen, 32'd0);
    chk("dis_strobes", strobes - s0, 32'd0);
    bit_t(1'b1, BIT);
    divisor = 16'd27;
    bit_t(1'b1, BIT);
    expect_byte(8'h3C, 8);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    bit_t(1'b1, BIT);
    chk("en_rx_data", {24'd0, rx_data}, 32'h3C);
    flags("en", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
